// File: rtl/riscv_pkg.sv
// Shared instruction-memory geometry and program-loader state encoding.
// Pure declarations; no logic and no flow control of its own.
package riscv_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 7;
  localparam int IMEM_DEPTH = 1 << ADDR_W;
  localparam int LEN_W      = 8;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } ld_state_e;

  // Requests longer than the memory are clipped so the address can never wrap.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/inst_word_assembler.sv
// Packs accepted bytes little-endian into a word; word_done flags the 4th byte combinationally.
// Zero latency (word_nxt already includes the current byte); never stalls, the caller gates accept.
module inst_word_assembler
  import riscv_pkg::*;
#(
  parameter int WORD_W_P = WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                accept,
  input  logic [7:0]          byte_data,
  output logic [WORD_W_P-1:0] word_nxt,
  output logic                word_done
);

  logic [1:0]          bcnt_q, bcnt_d;
  logic [WORD_W_P-1:0] word_q, word_d;

  always_comb begin
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    word_done = 1'b0;
    if (clear) begin
      bcnt_d = 2'd0;
    end else if (accept) begin
      word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
      bcnt_d    = bcnt_q + 2'd1;
      word_done = (bcnt_q == 2'd3);
    end
  end

  assign word_nxt = word_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= 2'd0;
      word_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Streams program bytes into instruction memory, one write per assembled word, then pulses done.
// Write lands one cycle after the 4th byte; byte_ready is high only while collecting (max 1 word / 5 cycles).
module inst_loader
  import riscv_pkg::*;
#(
  parameter int WORD_W_P = WORD_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [LEN_W-1:0]    load_len,
  input  logic                abort,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                inst_wen,
  output logic [ADDR_W_P-1:0] inst_addr,
  output logic [WORD_W_P-1:0] inst_data,
  output logic                busy,
  output logic                done
);

  ld_state_e           state_q, state_d;
  logic [ADDR_W_P-1:0] word_cnt_q, word_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W_P-1:0] addr_q, addr_d;
  logic [WORD_W_P-1:0] data_q, data_d;
  logic                rdy_q;

  logic                asm_clear, asm_accept, asm_done;
  logic [WORD_W_P-1:0] asm_word;
  logic [LEN_W-1:0]    words_written;

  assign asm_accept    = (state_q == LD_COLLECT) && byte_valid && !abort;
  assign words_written = LEN_W'(word_cnt_q) + LEN_W'(1);

  inst_word_assembler #(.WORD_W_P(WORD_W_P)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .accept    (asm_accept),
    .byte_data (byte_data),
    .word_nxt  (asm_word),
    .word_done (asm_done)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    asm_clear  = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        // rdy_q holds off load_start for the first edge after reset release
        if (load_start && rdy_q) begin
          word_cnt_d = '0;
          len_d      = sat_len(load_len);
          asm_clear  = 1'b1;
          state_d    = (load_len == '0) ? LD_DONE : LD_COLLECT;
        end
      end
      LD_COLLECT: begin
        if (abort) begin
          asm_clear = 1'b1;
          state_d   = LD_IDLE;
        end else if (asm_done) begin
          addr_d  = word_cnt_q;
          data_d  = asm_word;
          state_d = LD_WRITE;
        end
      end
      LD_WRITE: begin
        if (abort) begin
          asm_clear = 1'b1;
          state_d   = LD_IDLE;
        end else if (words_written < len_q) begin
          word_cnt_d = word_cnt_q + ADDR_W_P'(1);
          state_d    = LD_COLLECT;
        end else begin
          state_d = LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LD_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdy_q      <= 1'b1;
    end
  end

  assign byte_ready = (state_q == LD_COLLECT);
  assign inst_wen   = (state_q == LD_WRITE);
  assign busy       = (state_q != LD_IDLE);
  assign done       = (state_q == LD_DONE);
  assign inst_addr  = addr_q;
  assign inst_data  = data_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: reset, timing of a single word, gapped stream,
// saturation to 128 words, abort, mid-load reset, zero length and ignored load_start.
module tb_inst_loader;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_start = 1'b0;
  logic [LEN_W-1:0]  load_len = '0;
  logic              abort = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, inst_wen, busy, done;
  logic [ADDR_W-1:0] inst_addr;
  logic [WORD_W-1:0] inst_data;

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [WORD_W-1:0] wr_data[$];
  int done_cnt = 0;
  int rdy_viol = 0;

  inst_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .abort      (abort),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .inst_wen   (inst_wen),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_wen) begin
      wr_addr.push_back(inst_addr);
      wr_data.push_back(inst_data);
      if (byte_ready) rdy_viol++;
    end
    if (done) done_cnt++;
  end

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    rdy_viol = 0;
  endtask

  task automatic start(input logic [7:0] len);
    load_len   = len;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t          = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk_vec("byte_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w3 [3];
    logic [7:0]  b1 [4];
    w3[0] = 32'h00500093;
    w3[1] = 32'h00a00113;
    w3[2] = 32'h002081b3;
    b1[0] = 8'h13; b1[1] = 8'h00; b1[2] = 8'h00; b1[3] = 8'h00;

    // Reset state
    #2;
    chk_vec("rst_wen",   32'(inst_wen),   32'd0);
    chk_vec("rst_busy",  32'(busy),       32'd0);
    chk_vec("rst_done",  32'(done),       32'd0);
    chk_vec("rst_ready", 32'(byte_ready), 32'd0);
    chk_vec("rst_addr",  32'(inst_addr),  32'd0);
    chk_vec("rst_data",  inst_data,       32'd0);

    // Release; load_start on the first edge after release is not honoured
    @(negedge clk);
    rst        = 1'b1;
    load_len   = 8'd1;
    load_start = 1'b1;
    @(negedge clk);
    chk_vec("start_gated_busy", 32'(busy), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    chk_vec("start_busy",  32'(busy),       32'd1);
    chk_vec("start_ready", 32'(byte_ready), 32'd1);

    // Single word, back-to-back bytes, cycle-exact
    for (int k = 0; k < 4; k++) begin
      byte_valid = 1'b1;
      byte_data  = b1[k];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk_vec("w1_wen",   32'(inst_wen),   32'd1);
    chk_vec("w1_addr",  32'(inst_addr),  32'd0);
    chk_vec("w1_data",  inst_data,       32'h00000013);
    chk_vec("w1_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    chk_vec("w1_done",     32'(done),     32'd1);
    chk_vec("w1_done_wen", 32'(inst_wen), 32'd0);
    chk_vec("w1_done_bsy", 32'(busy),     32'd1);
    @(negedge clk);
    chk_vec("w1_idle_busy", 32'(busy),  32'd0);
    chk_vec("w1_idle_done", 32'(done),  32'd0);
    chk_vec("w1_hold_data", inst_data,  32'h00000013);

    // Three words with gaps between bytes
    clear_log();
    start(8'd3);
    send_word(w3[0], 1);
    send_word(w3[1], 0);
    send_word(w3[2], 2);
    idle(3);
    chk_vec("w3_count", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk_vec($sformatf("w3_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      chk_vec($sformatf("w3_data%0d", i), wr_data[i], w3[i]);
    end
    chk_vec("w3_done_cnt", 32'(done_cnt), 32'd1);
    chk_vec("w3_rdy_viol", 32'(rdy_viol), 32'd0);

    // Length 200 saturates to 128 words
    clear_log();
    start(8'd200);
    for (int i = 0; i < 128; i++) send_word(32'hA5000000 | 32'(i), 0);
    idle(3);
    chk_vec("sat_count", 32'(wr_addr.size()), 32'd128);
    for (int i = 0; i < 128; i++) begin
      chk_vec($sformatf("sat_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      chk_vec($sformatf("sat_data%0d", i), wr_data[i], 32'hA5000000 | 32'(i));
    end
    chk_vec("sat_done_cnt", 32'(done_cnt), 32'd1);
    chk_vec("sat_busy",     32'(busy),     32'd0);
    // Bytes offered while idle are not consumed
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    idle(4);
    chk_vec("idle_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk_vec("idle_count", 32'(wr_addr.size()), 32'd128);

    // Abort with the 3rd byte of word 2
    clear_log();
    start(8'd5);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_byte(8'h33);
    send_byte(8'h33);
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    abort      = 1'b1;
    chk_vec("abort_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    abort      = 1'b0;
    byte_valid = 1'b0;
    chk_vec("abort_busy",  32'(busy),       32'd0);
    chk_vec("abort_rdy0",  32'(byte_ready), 32'd0);
    idle(3);
    chk_vec("abort_count", 32'(wr_addr.size()), 32'd2);
    chk_vec("abort_done",  32'(done_cnt),       32'd0);
    clear_log();
    start(8'd1);
    send_word(32'h11223344, 0);
    idle(3);
    chk_vec("reload_count", 32'(wr_addr.size()), 32'd1);
    chk_vec("reload_addr",  32'(wr_addr[0]),     32'd0);
    chk_vec("reload_data",  wr_data[0],          32'h11223344);
    chk_vec("reload_done",  32'(done_cnt),       32'd1);

    // Reset asserted while collecting word 1
    clear_log();
    start(8'd3);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    #2 rst = 1'b0;
    #1;
    chk_vec("mrst_wen",   32'(inst_wen),   32'd0);
    chk_vec("mrst_busy",  32'(busy),       32'd0);
    chk_vec("mrst_ready", 32'(byte_ready), 32'd0);
    chk_vec("mrst_done",  32'(done),       32'd0);
    chk_vec("mrst_addr",  32'(inst_addr),  32'd0);
    chk_vec("mrst_data",  inst_data,       32'd0);
    @(negedge clk);
    rst        = 1'b1;
    byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      byte_data = 8'(i);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk_vec("mrst_count", 32'(wr_addr.size()), 32'd1);
    chk_vec("mrst_busy2", 32'(busy),           32'd0);

    // Zero length, with load_start held through the DONE cycle
    clear_log();
    load_len   = 8'd0;
    load_start = 1'b1;
    @(negedge clk);
    load_len = 8'd2;
    chk_vec("zero_done", 32'(done), 32'd1);
    chk_vec("zero_busy", 32'(busy), 32'd1);
    @(negedge clk);
    load_start = 1'b0;
    chk_vec("zero_idle_busy", 32'(busy), 32'd0);
    chk_vec("zero_idle_done", 32'(done), 32'd0);
    chk_vec("zero_count", 32'(wr_addr.size()), 32'd0);

    // load_start while collecting is ignored
    clear_log();
    start(8'd1);
    load_len   = 8'd5;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_word(32'h0BADBEEF, 0);
    idle(3);
    chk_vec("busy_start_count", 32'(wr_addr.size()), 32'd1);
    chk_vec("busy_start_data",  wr_data[0],          32'h0BADBEEF);
    chk_vec("busy_start_done",  32'(done_cnt),       32'd1);
    chk_vec("busy_start_idle",  32'(busy),           32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter WORD_W, default 32: width of one instruction word.
REQ-002 Parameter ADDR_W, default 7: instruction-memory word-address width; depth 2**ADDR_W = 128.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load_start  input  1  one-cycle request to begin a load; ignored unless IDLE.
REQ-006 load_len  input  8  words to load, sampled on an accepted load_start.
REQ-007 abort  input  1  synchronous abort of a load in progress.
REQ-008 byte_data  input  8  incoming program byte, little-endian within each word.
REQ-009 byte_valid  input  1  byte_data valid.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 inst_wen  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-012 inst_addr  output  ADDR_W  instruction-memory word address.
REQ-013 inst_data  output  WORD_W  assembled word to write.
REQ-014 busy  output  1  high in every state except IDLE; the core is held while busy.
REQ-015 done  output  1  one-cycle pulse when a load completes normally.

Function
REQ-016 FSM states: IDLE, COLLECT, WRITE, DONE; the encoding is registered.
REQ-017 IDLE -> COLLECT on load_start; word counter and byte counter clear; length latched.
REQ-018 load_len == 0 -> IDLE -> DONE directly; no inst_wen pulse is issued.
REQ-019 load_len > 128 saturates to 128.
REQ-020 byte_ready = 1 only in COLLECT; a byte is accepted when byte_valid && byte_ready.
REQ-021 Accepted byte k (k = 0..3) lands in inst_data bits [8k+7:8k].
REQ-022 After the 4th byte is accepted in cycle N, the state is WRITE in cycle N+1: inst_wen=1, inst_addr=word counter, inst_data=assembled word; byte_ready=0.
REQ-023 WRITE -> COLLECT with word counter+1 if words written < latched length; otherwise WRITE -> DONE.
REQ-024 DONE lasts exactly one cycle with done=1, then IDLE; busy=1 in DONE.
REQ-025 inst_wen=0 in all states except WRITE; inst_addr and inst_data hold their last values outside WRITE.
REQ-026 The word counter never wraps; the address reaches at most 127.
REQ-027 abort in COLLECT or WRITE -> IDLE next cycle; abort has priority over a simultaneous byte accept or write, so no write occurs in that cycle; done is not pulsed; partial word discarded.
REQ-028 abort in IDLE or DONE is ignored.
REQ-029 load_start while busy is ignored, including in the DONE cycle.
REQ-030 byte_valid while not in COLLECT is ignored; no byte is consumed.
REQ-031 Throughput: at most one word per 5 cycles (4 accept + 1 write).

Reset
REQ-032 rst low asynchronously forces: state IDLE, counters 0, latched length 0, byte_ready=0, inst_wen=0, inst_addr=0, inst_data=0, busy=0, done=0.
REQ-033 Reset asserted mid-load abandons the load; no further inst_wen pulse occurs after release until a new load_start.
REQ-034 Reset release is used synchronously; the first load_start is honoured on the second rising edge after release.

Structure
REQ-035 Shared package riscv_pkg holds WORD_W, ADDR_W, IMEM_DEPTH and the loader state enum.
REQ-036 Byte-to-word packing (2-bit byte counter, 32-bit shift/insert register, word-complete flag) is one sub-module, inst_word_assembler; the FSM, counters and write port live in inst_loader.
REQ-037 All outputs are registered or decoded only from the registered state.

Verification
REQ-038 load_len=1; bytes 0x13,0x00,0x00,0x00 back-to-back -> one inst_wen pulse with addr 0 and data 0x00000013 one cycle after the last byte, done pulse the following cycle, busy low after that.
REQ-039 load_len=3; 12 bytes with random byte_valid gaps -> three writes to addr 0,1,2 with correct little-endian words; byte_ready low during each WRITE cycle.
REQ-040 load_len=200 -> exactly 128 writes to addr 0..127, then done; no address wrap.
REQ-041 abort asserted with the 3rd byte of word 2 -> no write to addr 2, no done, IDLE next cycle; a new load_start=1 then writes addr 0.
REQ-042 rst low during COLLECT of word 1 -> all outputs 0 immediately; after release, no inst_wen until load_start.
REQ-043 load_len=0 -> done pulse with zero inst_wen pulses; load_start during busy is ignored.
